// File: rtl/phase_clock_sequencer_if.sv
// Control/status bundle between debug control (master) and the phase clock sequencer (slave).
// Optional cycle-limit signals exist only when CYCLE_LIMIT_EN is defined.
interface phase_clock_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run_i;
    logic             step_i;
    logic             halt_i;
    logic             ph1_o;
    logic             ph2_o;
    logic             cycle_start_o;
    logic             running_o;
    logic [CNT_W-1:0] cycle_cnt_o;
`ifdef CYCLE_LIMIT_EN
    logic [CNT_W-1:0] limit_i;
    logic             limit_hit_o;

    modport master (
        output run_i, step_i, halt_i, limit_i,
        input  ph1_o, ph2_o, cycle_start_o, running_o, cycle_cnt_o, limit_hit_o
    );
    modport slave (
        input  run_i, step_i, halt_i, limit_i,
        output ph1_o, ph2_o, cycle_start_o, running_o, cycle_cnt_o, limit_hit_o
    );
`else
    modport master (
        output run_i, step_i, halt_i,
        input  ph1_o, ph2_o, cycle_start_o, running_o, cycle_cnt_o
    );
    modport slave (
        input  run_i, step_i, halt_i,
        output ph1_o, ph2_o, cycle_start_o, running_o, cycle_cnt_o
    );
`endif
endinterface

// File: rtl/phase_clock_sequencer.sv
// Two-phase non-overlapping clock-enable sequencer with run/halt/step control and cycle counter.
// Optional feature: define CYCLE_LIMIT_EN to stop after limit_i CPU cycles.
module phase_clock_sequencer #(
    parameter int unsigned PH1_W = 8,
    parameter int unsigned GAP_W = 2,
    parameter int unsigned PH2_W = 8,
    parameter int unsigned CNT_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    phase_clock_sequencer_if.slave bus_io
);
    localparam int unsigned MAX_PH = (PH1_W > PH2_W) ? PH1_W : PH2_W;
    localparam int unsigned MAX_W  = (MAX_PH > GAP_W) ? MAX_PH : GAP_W;
    localparam int unsigned TICK_W = (MAX_W < 2) ? 1 : $clog2(MAX_W);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PH1  = 3'd1;
    localparam logic [2:0] ST_GAP1 = 3'd2;
    localparam logic [2:0] ST_PH2  = 3'd3;
    localparam logic [2:0] ST_GAP2 = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TICK_W-1:0] last_tick;
    logic              halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ph1_q, ph2_q, start_q, running_q;
    logic              last;
    logic              start_req;
    logic              limit_stop;
    logic              first_ph1;

`ifdef CYCLE_LIMIT_EN
    logic limit_hit_q, limit_hit_d;
    assign limit_stop = (bus_io.limit_i != '0) && (cnt_q == bus_io.limit_i);
    // A reached limit blocks free-run restart until an explicit step.
    assign start_req  = bus_io.step_i || (bus_io.run_i && !limit_hit_q);
`else
    assign limit_stop = 1'b0;
    assign start_req  = bus_io.step_i || bus_io.run_i;
`endif

    always_comb begin
        last_tick = '0;
        unique case (state_q)
            ST_PH1:  last_tick = TICK_W'(PH1_W - 1);
            ST_PH2:  last_tick = TICK_W'(PH2_W - 1);
            ST_GAP1: last_tick = TICK_W'(GAP_W - 1);
            ST_GAP2: last_tick = TICK_W'(GAP_W - 1);
            default: last_tick = '0;
        endcase
    end

    assign last      = (tick_q == last_tick);
    assign first_ph1 = (state_q == ST_PH1) && (tick_q == '0);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + TICK_W'(1);
        halt_pend_d = halt_pend_q;
        case (state_q)
            ST_IDLE: if (start_req) state_d = ST_PH1;
            ST_PH1:  if (last) state_d = ST_GAP1;
            ST_GAP1: if (last) state_d = ST_PH2;
            ST_PH2:  if (last) state_d = ST_GAP2;
            ST_GAP2: begin
                if (last) begin
                    if (bus_io.run_i && !halt_pend_q && !limit_stop) state_d = ST_PH1;
                    else                                           state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q || state_q == ST_IDLE) tick_d = '0;
        if (state_q != ST_IDLE && bus_io.halt_i) halt_pend_d = 1'b1;
        if (state_d == ST_IDLE) halt_pend_d = 1'b0;
    end

    assign cnt_d = first_ph1 ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            halt_pend_q <= 1'b0;
            cnt_q       <= '0;
            ph1_q       <= 1'b0;
            ph2_q       <= 1'b0;
            start_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            halt_pend_q <= halt_pend_d;
            cnt_q       <= cnt_d;
            // Outputs are registered decodes of the current state, one clk behind it.
            ph1_q       <= (state_q == ST_PH1);
            ph2_q       <= (state_q == ST_PH2);
            start_q     <= first_ph1;
            running_q   <= (state_q != ST_IDLE);
        end
    end

`ifdef CYCLE_LIMIT_EN
    always_comb begin
        limit_hit_d = limit_hit_q;
        if (state_q == ST_GAP2 && last && limit_stop)   limit_hit_d = 1'b1;
        if (state_q == ST_IDLE && state_d == ST_PH1)    limit_hit_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) limit_hit_q <= 1'b0;
        else        limit_hit_q <= limit_hit_d;
    end

    assign bus_io.limit_hit_o = limit_hit_q;
`endif

    assign bus_io.ph1_o         = ph1_q;
    assign bus_io.ph2_o         = ph2_q;
    assign bus_io.cycle_start_o = start_q;
    assign bus_io.running_o     = running_q;
    assign bus_io.cycle_cnt_o   = cnt_q;
endmodule

// File: tb/tb_phase_clock_sequencer.sv
// Directed bench for phase_clock_sequencer; expected cycle counts are queued per started cycle.
// Builds with or without CYCLE_LIMIT_EN.
module tb_phase_clock_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    phase_clock_sequencer_if #(.CNT_W(32)) a_if ();
    phase_clock_sequencer_if #(.CNT_W(4))  w_if ();

    phase_clock_sequencer #(.PH1_W(8), .GAP_W(2), .PH2_W(8), .CNT_W(32)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (a_if.slave)
    );

    phase_clock_sequencer #(.PH1_W(8), .GAP_W(2), .PH2_W(8), .CNT_W(4)) u_wrap (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (w_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_w[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every cycle_start_o pulse must match the next queued count.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("no_overlap_a", 64'(a_if.ph1_o & a_if.ph2_o), 64'd0);
            check("no_overlap_w", 64'(w_if.ph1_o & w_if.ph2_o), 64'd0);
            if (a_if.cycle_start_o === 1'b1) begin
                check("start_pending_a", 64'(exp_a.size() > 0), 64'd1);
                if (exp_a.size() > 0) check("start_cnt_a", 64'(a_if.cycle_cnt_o), 64'(exp_a.pop_front()));
            end
            if (w_if.cycle_start_o === 1'b1) begin
                check("start_pending_w", 64'(exp_w.size() > 0), 64'd1);
                if (exp_w.size() > 0) check("start_cnt_w", 64'(w_if.cycle_cnt_o), 64'(exp_w.pop_front()));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        a_if.run_i = 1'b0; a_if.step_i = 1'b0; a_if.halt_i = 1'b0;
        w_if.run_i = 1'b0; w_if.step_i = 1'b0; w_if.halt_i = 1'b0;
`ifdef CYCLE_LIMIT_EN
        a_if.limit_i = '0;
        w_if.limit_i = '0;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ph1", 64'(a_if.ph1_o), 64'd0);
        check("rst_ph2", 64'(a_if.ph2_o), 64'd0);
        check("rst_start", 64'(a_if.cycle_start_o), 64'd0);
        check("rst_running", 64'(a_if.running_o), 64'd0);
        check("rst_cnt", 64'(a_if.cycle_cnt_o), 64'd0);
`ifdef CYCLE_LIMIT_EN
        check("rst_limit_hit", 64'(a_if.limit_hit_o), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single step: step sampled at edge 0.
        a_if.step_i = 1'b1;
        exp_a.push_back(1);
        for (int e = 0; e <= 22; e++) begin
            @(negedge clk);
            a_if.step_i = 1'b0;
            check("step_ph1", 64'(a_if.ph1_o), 64'(e >= 1 && e <= 8));
            check("step_ph2", 64'(a_if.ph2_o), 64'(e >= 11 && e <= 18));
            check("step_running", 64'(a_if.running_o), 64'(e >= 1 && e <= 20));
            check("step_start", 64'(a_if.cycle_start_o), 64'(e == 1));
        end
        check("step_cnt", 64'(a_if.cycle_cnt_o), 64'd1);

        // Free run for three periods.
        do_reset();
        a_if.run_i = 1'b1;
        exp_a.push_back(1); exp_a.push_back(2); exp_a.push_back(3);
        for (int e = 0; e <= 62; e++) begin
            @(negedge clk);
            check("run_start", 64'(a_if.cycle_start_o), 64'(e == 1 || e == 21 || e == 41));
            check("run_running", 64'(a_if.running_o), 64'(e >= 1 && e <= 60));
            if (e == 45) a_if.run_i = 1'b0;
        end
        check("run_cnt", 64'(a_if.cycle_cnt_o), 64'd3);

        // Halt during first PH2 while run held.
        do_reset();
        a_if.run_i = 1'b1;
        exp_a.push_back(1);
        for (int e = 0; e <= 24; e++) begin
            @(negedge clk);
            check("halt_running", 64'(a_if.running_o), 64'(e >= 1 && e <= 20));
            check("halt_ph2", 64'(a_if.ph2_o), 64'(e >= 11 && e <= 18));
            a_if.halt_i = (e == 12);
            if (e == 20) a_if.run_i = 1'b0;
        end
        check("halt_cnt", 64'(a_if.cycle_cnt_o), 64'd1);

        // Asynchronous reset in the middle of PH2.
        do_reset();
        a_if.run_i = 1'b1;
        exp_a.push_back(1);
        repeat (14) @(negedge clk);
        check("pre_rst_ph2", 64'(a_if.ph2_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ph1", 64'(a_if.ph1_o), 64'd0);
        check("arst_ph2", 64'(a_if.ph2_o), 64'd0);
        check("arst_running", 64'(a_if.running_o), 64'd0);
        check("arst_cnt", 64'(a_if.cycle_cnt_o), 64'd0);
        a_if.run_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Counter wrap on the 4-bit instance: 17 cycles.
        w_if.run_i = 1'b1;
        for (int i = 1; i <= 17; i++) exp_w.push_back(i % 16);
        for (int e = 0; e <= 345; e++) begin
            @(negedge clk);
            if (e == 330) w_if.run_i = 1'b0;
        end
        check("wrap_cnt", 64'(w_if.cycle_cnt_o), 64'd1);
        check("wrap_running", 64'(w_if.running_o), 64'd0);

`ifdef CYCLE_LIMIT_EN
        do_reset();
        a_if.limit_i = 32'd2;
        a_if.run_i   = 1'b1;
        exp_a.push_back(1); exp_a.push_back(2);
        for (int e = 0; e <= 50; e++) begin
            @(negedge clk);
            if (e == 38) check("limit_hit_early", 64'(a_if.limit_hit_o), 64'd0);
            if (e == 45 || e == 50) begin
                check("limit_running", 64'(a_if.running_o), 64'd0);
                check("limit_hit", 64'(a_if.limit_hit_o), 64'd1);
                check("limit_cnt", 64'(a_if.cycle_cnt_o), 64'd2);
            end
        end
        a_if.run_i  = 1'b0;
        a_if.step_i = 1'b1;
        exp_a.push_back(3);
        @(negedge clk);
        a_if.step_i = 1'b0;
        repeat (5) @(negedge clk);
        check("limit_clear", 64'(a_if.limit_hit_o), 64'd0);
        check("limit_step_running", 64'(a_if.running_o), 64'd1);
        repeat (20) @(negedge clk);
        check("limit_step_done", 64'(a_if.running_o), 64'd0);
        check("limit_step_cnt", 64'(a_if.cycle_cnt_o), 64'd3);
`endif

        check("queue_a_drained", 64'(exp_a.size()), 64'd0);
        check("queue_w_drained", 64'(exp_w.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
